// File: rtl/ic74x_down_counter.sv
// Presettable synchronous binary down counter with 74x163-style enables,
// cascadable borrow output, optional auto-reload and a terminal-count pulse.
module ic74x_down_counter #(
  parameter int unsigned          WIDTH          = 4,
  parameter logic [WIDTH-1:0]     RELOAD_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             auto_rl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             bco,
  output logic             tc_pulse
);

  logic [WIDTH-1:0] rl_reg;
  logic             q_zero;

  assign q_zero = (q == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      q        <= '0;
      rl_reg   <= RELOAD_DEFAULT;
      tc_pulse <= 1'b0;
    end else if (!ld_n) begin
      q        <= d;
      rl_reg   <= d;
      tc_pulse <= 1'b0;
    end else if (enp && ent) begin
      // The terminal-count step is the only source of tc_pulse; a load of zero is not.
      if (q_zero) begin
        q        <= auto_rl ? rl_reg : '1;
        tc_pulse <= 1'b1;
      end else begin
        q        <= q - 1'b1;
        tc_pulse <= 1'b0;
      end
    end else begin
      tc_pulse <= 1'b0;
    end
  end

  // Combinational like 74x163 rco: ignores enp so stages chain through ent.
  assign bco = ent && q_zero;

endmodule

// File: tb/tb_ic74x_down_counter.sv
// Directed bench for ic74x_down_counter: single instance plus an 8-bit
// two-stage cascade, checked against a queue of expected results.
module tb_ic74x_down_counter;

  localparam logic [3:0] RL_DEF = 4'h7;

  logic       clk = 1'b0;
  logic       clr = 1'b0, ld_n = 1'b1, enp = 1'b0, ent = 1'b0, auto_rl = 1'b0;
  logic [3:0] d = 4'h0;
  logic [3:0] q;
  logic       bco, tc_pulse;

  // cascade stimulus / observation
  logic       c_clr = 1'b0, c_ld_n = 1'b1, c_enp = 1'b0, c_ent = 1'b0;
  logic [7:0] c_d = 8'h00;
  logic [3:0] ql, qh;
  logic       bco_l, bco_h, tc_l, tc_h;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       bco;
    string      tag;
  } exp_t;

  typedef struct {
    logic [7:0] v;
    logic [1:0] tc;
    string      tag;
  } cexp_t;

  exp_t  sb[$];
  cexp_t csb[$];

  always #5 clk = ~clk;

  ic74x_down_counter #(.WIDTH(4), .RELOAD_DEFAULT(RL_DEF)) dut (
    .clk(clk), .clr(clr), .ld_n(ld_n), .enp(enp), .ent(ent), .auto_rl(auto_rl),
    .d(d), .q(q), .bco(bco), .tc_pulse(tc_pulse)
  );

  ic74x_down_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .clr(c_clr), .ld_n(c_ld_n), .enp(c_enp), .ent(c_ent), .auto_rl(1'b0),
    .d(c_d[3:0]), .q(ql), .bco(bco_l), .tc_pulse(tc_l)
  );

  ic74x_down_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .clr(c_clr), .ld_n(c_ld_n), .enp(c_enp), .ent(bco_l), .auto_rl(1'b0),
    .d(c_d[7:4]), .q(qh), .bco(bco_h), .tc_pulse(tc_h)
  );

  // Drive one cycle of inputs, queue the expected post-edge result, then check it.
  task automatic step(input logic c, input logic ldn, input logic p, input logic t,
                      input logic ar, input logic [3:0] dd, input logic [3:0] eq,
                      input logic etc, input logic ebco, input string tag);
    exp_t e;
    @(negedge clk);
    clr = c; ld_n = ldn; enp = p; ent = t; auto_rl = ar; d = dd;
    sb.push_back('{q: eq, tc: etc, bco: ebco, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (q === e.q) else begin
      fails++;
      $error("FAIL %s q: got %h expected %h", e.tag, q, e.q);
    end
    checks++;
    assert (tc_pulse === e.tc) else begin
      fails++;
      $error("FAIL %s tc_pulse: got %b expected %b", e.tag, tc_pulse, e.tc);
    end
    checks++;
    assert (bco === e.bco) else begin
      fails++;
      $error("FAIL %s bco: got %b expected %b", e.tag, bco, e.bco);
    end
  endtask

  task automatic cstep(input logic ldn, input logic p, input logic [7:0] dd,
                       input logic [7:0] ev, input logic [1:0] etc, input string tag);
    cexp_t e;
    @(negedge clk);
    c_clr = 1'b0; c_ld_n = ldn; c_enp = p; c_ent = 1'b1; c_d = dd;
    csb.push_back('{v: ev, tc: etc, tag: tag});
    @(posedge clk);
    #1;
    e = csb.pop_front();
    checks++;
    assert ({qh, ql} === e.v) else begin
      fails++;
      $error("FAIL %s value: got %h expected %h", e.tag, {qh, ql}, e.v);
    end
    checks++;
    assert ({tc_h, tc_l} === e.tc) else begin
      fails++;
      $error("FAIL %s tc{hi,lo}: got %b expected %b", e.tag, {tc_h, tc_l}, e.tc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1 reset with load and count also requested
    step(1, 0, 1, 1, 0, 4'hA, 4'h0, 0, 1, "rst1");
    step(1, 0, 1, 1, 0, 4'hA, 4'h0, 0, 1, "rst2");
    step(0, 1, 1, 1, 1, 4'h0, RL_DEF, 1, 0, "rst_reload");
    step(0, 1, 1, 1, 1, 4'h0, RL_DEF - 4'h1, 0, 0, "rst_reload_next");

    // 2 wrap without auto-reload
    step(0, 0, 0, 0, 0, 4'h5, 4'h5, 0, 0, "wrap_load");
    step(0, 1, 1, 1, 0, 4'h0, 4'h4, 0, 0, "wrap_4");
    step(0, 1, 1, 1, 0, 4'h0, 4'h3, 0, 0, "wrap_3");
    step(0, 1, 1, 1, 0, 4'h0, 4'h2, 0, 0, "wrap_2");
    step(0, 1, 1, 1, 0, 4'h0, 4'h1, 0, 0, "wrap_1");
    step(0, 1, 1, 1, 0, 4'h0, 4'h0, 0, 1, "wrap_0");
    step(0, 1, 1, 1, 0, 4'h0, 4'hF, 1, 0, "wrap_F");
    step(0, 1, 1, 1, 0, 4'h0, 4'hE, 0, 0, "wrap_E");

    // 3 auto-reload from 3
    step(0, 0, 1, 1, 1, 4'h3, 4'h3, 0, 0, "arl_load");
    step(0, 1, 1, 1, 1, 4'h0, 4'h2, 0, 0, "arl_a2");
    step(0, 1, 1, 1, 1, 4'h0, 4'h1, 0, 0, "arl_a1");
    step(0, 1, 1, 1, 1, 4'h0, 4'h0, 0, 1, "arl_a0");
    step(0, 1, 1, 1, 1, 4'h0, 4'h3, 1, 0, "arl_r3a");
    step(0, 1, 1, 1, 1, 4'h0, 4'h2, 0, 0, "arl_b2");
    step(0, 1, 1, 1, 1, 4'h0, 4'h1, 0, 0, "arl_b1");
    step(0, 1, 1, 1, 1, 4'h0, 4'h0, 0, 1, "arl_b0");
    step(0, 1, 1, 1, 1, 4'h0, 4'h3, 1, 0, "arl_r3b");
    step(0, 1, 1, 1, 1, 4'h0, 4'h2, 0, 0, "arl_c2");

    // 4 enables, plus zero reload value
    step(0, 0, 1, 1, 1, 4'h0, 4'h0, 0, 1, "load_zero_no_tc");
    step(0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 1, "en_enp0");
    step(0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 0, "en_ent0");
    step(0, 1, 1, 1, 1, 4'h0, 4'h0, 1, 1, "rl0_stay_a");
    step(0, 1, 1, 1, 1, 4'h0, 4'h0, 1, 1, "rl0_stay_b");
    step(0, 1, 1, 1, 0, 4'h0, 4'hF, 1, 0, "en_wrap");

    // 6 priority: clr beats load/count, load beats count
    step(0, 0, 0, 0, 0, 4'h5, 4'h5, 0, 0, "pri_load");
    step(0, 1, 1, 1, 0, 4'h0, 4'h4, 0, 0, "pri_count");
    step(1, 0, 1, 1, 0, 4'h9, 4'h0, 0, 1, "pri_clr");
    step(0, 0, 1, 1, 0, 4'h9, 4'h9, 0, 0, "pri_load9");
    step(0, 1, 1, 1, 0, 4'h0, 4'h8, 0, 0, "pri_after");

    // 5 two-stage cascade
    @(negedge clk);
    c_clr = 1'b1;
    @(negedge clk);
    c_clr = 1'b0;
    cstep(0, 0, 8'h10, 8'h10, 2'b00, "cas_load");
    cstep(1, 1, 8'h00, 8'h0F, 2'b01, "cas_0F");
    for (int i = 0; i < 15; i++)
      cstep(1, 1, 8'h00, 8'h0E - 8'(i), 2'b00, "cas_run");
    cstep(1, 1, 8'h00, 8'hFF, 2'b11, "cas_FF");
    cstep(1, 0, 8'h00, 8'hFF, 2'b00, "cas_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
